fetch_bus_arb: RTL

// - Arbitrates the single external bus port between IFU fetches and LSU data accesses.
// - Guarantees that the two halves of a line/word-crossing instruction spill are granted

---
 rtl/fetch_bus_arb.sv | 49 ++++
 1 files changed

// File: rtl/fetch_bus_arb.sv
// fetch_bus_arb: IFU/LSU bus port arbiter with back-to-back spill grants and bounded IFU starvation
module fetch_bus_arb #(
  parameter int STARVELIMIT = 4,
  parameter int CNTW = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic IFUReq,
  input  logic IFUSpillLock,
  input  logic IFUFlush,
  input  logic LSUReq,
  input  logic BusDone,
  output logic IFUGnt,
  output logic LSUGnt,
  output logic BusReq,
  output logic BusSel,
  output logic IFUStall,
  output logic LSUStall
);
  localparam logic [1:0] IDLE = 2'd0, IFU = 2'd1, IFU_SPILL = 2'd2, LSU = 2'd3;
  logic [1:0] r_state, w_arb, w_next;
  logic [CNTW-1:0] r_cnt;
  logic r_lock_pend, w_starve, w_spill, w_lsu_entry, w_ifu_entry;
  always_comb begin
    w_starve = IFUReq & (r_cnt == CNTW'(STARVELIMIT));
    w_arb = LSUReq & ~w_starve ? LSU : IFUReq ? IFU : IDLE;
    w_spill = (IFUSpillLock | r_lock_pend) & ~IFUFlush;
    w_next = r_state == IDLE ? w_arb : ~BusDone ? r_state : r_state == IFU & w_spill ? IFU_SPILL : w_arb;
    w_lsu_entry = w_next == LSU & (r_state != LSU | BusDone);
    w_ifu_entry = w_next == IFU & (r_state != IFU | BusDone);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_lock_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      r_lock_pend <= r_state == IFU & ~BusDone & ~IFUFlush & (IFUSpillLock | r_lock_pend);
      r_cnt <= ~IFUReq | w_ifu_entry ? '0 : w_lsu_entry & ~w_starve ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign IFUGnt = r_state == IFU | r_state == IFU_SPILL;
  assign LSUGnt = r_state == LSU;
  assign BusReq = IFUGnt | LSUGnt;
  assign BusSel = LSUGnt;
  assign IFUStall = IFUReq & ~(IFUGnt & BusDone);
  assign LSUStall = LSUReq & ~(LSUGnt & BusDone);
endmodule
